// File: rtl/ex_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_loader_pkg
//  Purpose  : Shared types and constants for the execution-memory loader.
//             Holds the FSM state encoding, bus widths and the bit positions
//             of the fields inside a host header word.
//  Revision : 1.0 - initial release
// ============================================================================
package ex_mem_loader_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 9;
  localparam int SEL_W    = 5;
  localparam int SEL_LAST = 31;

  // Header word layout
  localparam int CMD_BIT  = 31;   // 0 = LOAD, 1 = DUMP
  localparam int BASE_LSB = 0;    // LOAD base address, ADDR_W bits
  localparam int CNT_LSB  = 9;    // LOAD entry count minus one, ADDR_W bits

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    W_I1     = 4'd1,
    W_I2     = 4'd2,
    W_D1     = 4'd3,
    W_D2     = 4'd4,
    WRITE    = 4'd5,
    DUMP_SEL = 4'd6,
    DUMP_CAP = 4'd7,
    DUMP_OUT = 4'd8
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ex_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_loader_if
//  Purpose  : Host-side streams of the loader.
//             s_* : host -> loader command/payload words (valid/ready)
//             m_* : loader -> host debug dump words (valid/ready)
//  Modports : master = host side, slave = loader side
//  Revision : 1.0 - initial release
// ============================================================================
interface ex_mem_loader_if;
  import ex_mem_loader_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

endinterface
`default_nettype wire

// File: rtl/ex_mem_loader_dbg_dump.sv
`default_nettype none
// ============================================================================
//  Module   : dbg_dump
//  Purpose  : Debug dump sequencer. On i_start walks the debug selector
//             0..31; for each selector it presents DebugSel (DUMP_SEL),
//             captures the core's debug value (DUMP_CAP) and offers it on
//             the output stream until accepted (DUMP_OUT). o_done pulses on
//             the handshake of the last word.
//  Ports    : clk, reset (async, active-low)
//             i_start, o_done        - start/done handshake with the loader
//             o_enable_debug, o_debug_sel, i_debug_output - core debug port
//             o_m_valid, i_m_ready, o_m_data              - dump stream
//  Revision : 1.0 - initial release
// ============================================================================
module dbg_dump
  import ex_mem_loader_pkg::*;
(
  input  wire               clk,
  input  wire               reset,
  input  wire               i_start,
  output logic              o_done,
  output logic              o_enable_debug,
  output logic [SEL_W-1:0]  o_debug_sel,
  input  wire  [DATA_W-1:0] i_debug_output,
  output logic              o_m_valid,
  input  wire               i_m_ready,
  output logic [DATA_W-1:0] o_m_data
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [DATA_W-1:0]  r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      // The selector has been stable for a full cycle here, so the core's
      // combinational debug value has settled.
      if (r_state == DUMP_CAP)
        r_data <= i_debug_output;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = DUMP_SEL;
          w_sel_nxt   = '0;
        end
      end
      DUMP_SEL: w_state_nxt = DUMP_CAP;
      DUMP_CAP: w_state_nxt = DUMP_OUT;
      DUMP_OUT: begin
        if (i_m_ready) begin
          if (r_sel == SEL_W'(SEL_LAST)) begin
            w_state_nxt = IDLE;
            w_sel_nxt   = '0;
            o_done      = 1'b1;
          end else begin
            w_state_nxt = DUMP_SEL;
            w_sel_nxt   = r_sel + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_enable_debug = (r_state != IDLE);
  assign o_debug_sel    = r_sel;
  assign o_m_valid      = (r_state == DUMP_OUT);
  assign o_m_data       = r_data;

endmodule
`default_nettype wire

// File: rtl/ex_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_loader
//  Purpose  : Loads instruction/data memories of a core from a host word
//             stream and dumps the core's debug registers back to the host.
//             LOAD header -> per entry 4 words (I1, I2, D1, D2) followed by
//             a one-cycle write strobe at (base + index) mod 512. The core
//             is held in reset until a LOAD completes.
//             DUMP header -> 32 debug words via the dbg_dump sequencer.
//  Ports    : clk, reset (async, active-low)
//             bus                   - host streams (slave modport)
//             enable_load_ex_mem    - memory write strobe
//             Inst/DataExMemAddress - write index (identical)
//             Inst/DataExMemData1/2 - write payload
//             core_reset            - core hold, active-high
//             enable_debug, DebugSel, DebugOutput - core debug port
//             busy                  - loader not idle
//  Revision : 1.0 - initial release
// ============================================================================
module ex_mem_loader
  import ex_mem_loader_pkg::*;
(
  input  wire               clk,
  input  wire               reset,
  ex_mem_loader_if.slave    bus,
  output logic              enable_load_ex_mem,
  output logic [ADDR_W-1:0] InstExMemAddress,
  output logic [ADDR_W-1:0] DataExMemAddress,
  output logic [DATA_W-1:0] InstExMemData1,
  output logic [DATA_W-1:0] InstExMemData2,
  output logic [DATA_W-1:0] DataExMemData1,
  output logic [DATA_W-1:0] DataExMemData2,
  output logic              core_reset,
  output logic              enable_debug,
  output logic [SEL_W-1:0]  DebugSel,
  input  wire  [DATA_W-1:0] DebugOutput,
  output logic              busy
);

  // DUMP_SEL in this FSM means "dump owned by dbg_dump"; the sub-module
  // carries the detailed SEL/CAP/OUT sequencing.
  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_live;        // low during reset, high from first edge after
  logic [ADDR_W-1:0]  r_base;
  logic [ADDR_W-1:0]  r_cnt;         // entries minus one
  logic [ADDR_W-1:0]  r_idx;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_i1;
  logic [DATA_W-1:0]  r_i2;
  logic [DATA_W-1:0]  r_d1;
  logic [DATA_W-1:0]  r_d2;
  logic               r_core_reset;
  logic               w_s_ready;
  logic               w_accept;
  logic               w_is_dump;
  logic               w_dump_start;
  logic               w_dump_done;
  logic               w_last;

  assign w_s_ready = r_live && ((r_state == IDLE) || (r_state == W_I1) ||
                                (r_state == W_I2) || (r_state == W_D1) ||
                                (r_state == W_D2));
  assign w_accept     = bus.s_valid && w_s_ready;
  assign w_is_dump    = bus.s_data[CMD_BIT];
  assign w_dump_start = (r_state == IDLE) && w_accept && w_is_dump;
  assign w_last       = (r_idx == r_cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_live       <= 1'b0;
      r_base       <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_addr       <= '0;
      r_i1         <= '0;
      r_i2         <= '0;
      r_d1         <= '0;
      r_d2         <= '0;
      r_core_reset <= 1'b1;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_accept && !w_is_dump) begin
            r_base       <= bus.s_data[BASE_LSB +: ADDR_W];
            r_cnt        <= bus.s_data[CNT_LSB  +: ADDR_W];
            r_idx        <= '0;
            r_core_reset <= 1'b1;
          end
        end
        W_I1: if (w_accept) r_i1 <= bus.s_data;
        W_I2: if (w_accept) r_i2 <= bus.s_data;
        W_D1: if (w_accept) r_d1 <= bus.s_data;
        W_D2: begin
          if (w_accept) begin
            r_d2   <= bus.s_data;
            // 9-bit sum wraps naturally at 512.
            r_addr <= r_base + r_idx;
          end
        end
        WRITE: begin
          if (w_last) r_core_reset <= 1'b0;
          else        r_idx        <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_state_nxt = w_is_dump ? DUMP_SEL : W_I1;
      W_I1:     if (w_accept) w_state_nxt = W_I2;
      W_I2:     if (w_accept) w_state_nxt = W_D1;
      W_D1:     if (w_accept) w_state_nxt = W_D2;
      W_D2:     if (w_accept) w_state_nxt = WRITE;
      WRITE:    w_state_nxt = w_last ? IDLE : W_I1;
      DUMP_SEL: if (w_dump_done) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  dbg_dump u_dbg_dump (
    .clk            (clk),
    .reset          (reset),
    .i_start        (w_dump_start),
    .o_done         (w_dump_done),
    .o_enable_debug (enable_debug),
    .o_debug_sel    (DebugSel),
    .i_debug_output (DebugOutput),
    .o_m_valid      (bus.m_valid),
    .i_m_ready      (bus.m_ready),
    .o_m_data       (bus.m_data)
  );

  assign bus.s_ready        = w_s_ready;
  assign enable_load_ex_mem = (r_state == WRITE);
  assign InstExMemAddress   = r_addr;
  assign DataExMemAddress   = r_addr;
  assign InstExMemData1     = r_i1;
  assign InstExMemData2     = r_i2;
  assign DataExMemData1     = r_d1;
  assign DataExMemData2     = r_d2;
  assign core_reset         = r_core_reset;
  assign busy               = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mem_loader
//  Purpose  : Self-checking bench for ex_mem_loader. LOAD cases come from a
//             vector table; expected memory writes and dump words are queued
//             when stimulus is driven and compared by a negedge monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        strobe;
  logic [8:0]  ia, da;
  logic [31:0] i1, i2, d1, d2;
  logic        core_reset, en_dbg, busy;
  logic [4:0]  sel;
  logic [31:0] dbg_out;

  always #5 clk = ~clk;

  ex_mem_loader_if bus();

  // Core model: debug value is a fixed function of the selector.
  assign dbg_out = 32'h100 + {27'd0, sel};

  ex_mem_loader dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .enable_load_ex_mem (strobe),
    .InstExMemAddress   (ia),
    .DataExMemAddress   (da),
    .InstExMemData1     (i1),
    .InstExMemData2     (i2),
    .DataExMemData1     (d1),
    .DataExMemData2     (d2),
    .core_reset         (core_reset),
    .enable_debug       (en_dbg),
    .DebugSel           (sel),
    .DebugOutput        (dbg_out),
    .busy               (busy)
  );

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] i1, i2, d1, d2;
  } wr_t;

  typedef struct {
    logic [31:0] hdr;
    int          n;       // expected number of strobes
    logic [8:0]  first;   // expected first write address
    int          gap;     // idle cycles between words
    bit          keep;    // hold s_valid high between words
  } vec_t;

  wr_t         wq[$];
  logic [31:0] dq[$];
  int          checks = 0;
  int          errors = 0;
  int          strobes = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic        prev_strobe = 1'b0;
  logic        hold_pend   = 1'b0;
  logic [31:0] held;
  wr_t         me;

  always @(negedge clk) begin
    if (!reset) begin
      prev_strobe = 1'b0;
      hold_pend   = 1'b0;
    end else begin
      if (strobe) begin
        chk("strobe_width", {31'd0, prev_strobe}, 32'd0);
        chk("s_ready_in_write", {31'd0, bus.s_ready}, 32'd0);
        chk("addr_equal", {23'd0, da}, {23'd0, ia});
        chk("core_reset_in_write", {31'd0, core_reset}, 32'd1);
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got strobe at addr %0d expected none", ia);
        end else begin
          me = wq.pop_front();
          chk("wr_addr", {23'd0, ia}, {23'd0, me.addr});
          chk("wr_i1", i1, me.i1);
          chk("wr_i2", i2, me.i2);
          chk("wr_d1", d1, me.d1);
          chk("wr_d2", d2, me.d2);
        end
        strobes++;
      end
      prev_strobe = strobe;

      if (bus.m_valid) begin
        chk("s_ready_in_dump", {31'd0, bus.s_ready}, 32'd0);
        if (hold_pend) chk("m_data_stable", bus.m_data, held);
        if (bus.m_ready) begin
          hold_pend = 1'b0;
          if (dq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_dump_word: got %h expected none", bus.m_data);
          end else begin
            chk("dump_word", bus.m_data, dq.pop_front());
          end
        end else begin
          hold_pend = 1'b1;
          held      = bus.m_data;
        end
      end
    end
  end

  // m_ready pattern: two cycles high, one low
  int cyc = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    bus.m_ready = (cyc % 3) != 0;
  end

  // ---------------- driver tasks (call at posedge+1) ----------------
  task automatic send(input logic [31:0] w, input bit keep);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    forever begin
      @(negedge clk);
      if (bus.s_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got s_ready=0 for %0d cycles expected 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) bus.s_valid = 1'b0;
  endtask

  task automatic do_load(input vec_t v);
    logic [31:0] w[4];
    wr_t         e;
    int          s0;
    logic [8:0]  la;
    s0 = strobes;
    send(v.hdr, v.keep);
    for (int k = 0; k < v.n; k++) begin
      for (int j = 0; j < 4; j++) w[j] = $urandom;
      e.addr = v.first + 9'(k);
      e.i1 = w[0]; e.i2 = w[1]; e.d1 = w[2]; e.d2 = w[3];
      wq.push_back(e);
      for (int j = 0; j < 4; j++) begin
        repeat (v.gap) begin @(posedge clk); #1; end
        send(w[j], v.keep && !(k == v.n - 1 && j == 3));
      end
    end
    @(negedge clk);
    chk("last_strobe", {31'd0, strobe}, 32'd1);
    chk("core_reset_on_last", {31'd0, core_reset}, 32'd1);
    @(negedge clk);
    chk("core_reset_fall", {31'd0, core_reset}, 32'd0);
    chk("busy_after_load", {31'd0, busy}, 32'd0);
    chk("no_extra_strobe", {31'd0, strobe}, 32'd0);
    chk("strobe_count", strobes - s0, v.n);
    chk("queue_drained", wq.size(), 0);
    la = v.first + 9'(v.n - 1);
    chk("addr_hold", {23'd0, ia}, {23'd0, la});
    chk("data_hold", d2, e.d2);
    @(posedge clk);
    #1;
  endtask

  task automatic do_dump(input logic [31:0] hdr);
    int   lim = 0;
    logic cr;
    cr = core_reset;
    for (int i = 0; i < 32; i++) dq.push_back(32'h100 + i);
    send(hdr, 1'b0);
    @(negedge clk);
    chk("dump_en_debug", {31'd0, en_dbg}, 32'd1);
    chk("dump_sel0", {27'd0, sel}, 32'd0);
    chk("dump_busy", {31'd0, busy}, 32'd1);
    // Junk LOAD header offered during the dump must be ignored.
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h0000_0000;
    while (dq.size() != 0 && lim < 2000) begin
      @(negedge clk);
      #1;
      lim++;
    end
    bus.s_valid = 1'b0;
    if (lim >= 2000) begin
      checks++;
      errors++;
      $display("FAIL dump_timeout: got %0d words left expected 0", dq.size());
    end
    @(posedge clk);
    #1;
    chk("dump_end_en_debug", {31'd0, en_dbg}, 32'd0);
    chk("dump_end_busy", {31'd0, busy}, 32'd0);
    chk("dump_end_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("dump_core_reset_kept", {31'd0, core_reset}, {31'd0, cr});
    chk("dump_end_s_ready", {31'd0, bus.s_ready}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  vec_t tbl[6];
  vec_t fresh;

  initial begin
    tbl[0] = '{32'h0000_0000,   1, 9'd0,   0, 1'b0};  // single entry at 0
    tbl[1] = '{32'h0000_07FE,   4, 9'd510, 0, 1'b0};  // wrap 510,511,0,1
    tbl[2] = '{32'h0000_0405,   3, 9'd5,   3, 1'b0};  // gaps between words
    tbl[3] = '{32'h0000_06C8,   4, 9'd200, 0, 1'b1};  // s_valid held across WRITE
    tbl[4] = '{32'h7FFC_0203,   2, 9'd3,   1, 1'b0};  // ignored header bits set
    tbl[5] = '{32'h0003_FE00, 512, 9'd0,   0, 1'b1};  // maximum count
    fresh  = '{32'h0000_0007,   1, 9'd7,   0, 1'b0};

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    reset       = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("rst_strobe", {31'd0, strobe}, 32'd0);
    chk("rst_en_debug", {31'd0, en_dbg}, 32'd0);
    chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sel", {27'd0, sel}, 32'd0);
    chk("rst_addr", {23'd0, ia}, 32'd0);
    chk("rst_i1", i1, 32'd0);
    chk("rst_d2", d2, 32'd0);
    chk("rst_m_data", bus.m_data, 32'd0);

    reset = 1'b1;
    @(negedge clk);
    chk("release_s_ready", {31'd0, bus.s_ready}, 32'd1);
    chk("release_core_reset", {31'd0, core_reset}, 32'd1);
    @(posedge clk);
    #1;

    // Dump while the core is still held
    do_dump(32'h8000_0000);

    for (int t = 0; t < 6; t++) do_load(tbl[t]);

    // Reset in the middle of an entry (after the D1 word)
    send(32'h0000_0000, 1'b0);
    send(32'h1111_1111, 1'b0);
    send(32'h2222_2222, 1'b0);
    send(32'h3333_3333, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("midrst_i1", i1, 32'd0);
    chk("midrst_strobe", {31'd0, strobe}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_load(fresh);

    do_dump(32'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
